lvds_echo_responder: RTL and testbench

Far-end (FPGA2) counterpart of the 4-bit LVDS echo link. Accepts framed nibbles already sampled into the `CLK` domain, reassembles each byte, buffers it, and re-serializes it back over the 4-bit return lanes with identical framing, so the initiating FPGA can compare echoed data. It sits between the LVDS input sampling stage and the LVDS output drivers, and exposes status counters for the link bring-up bench.

---
 rtl/lvds_echo_pkg.sv | 31 +++
 rtl/echo_fifo.sv | 51 +++++
 rtl/lvds_echo_responder.sv | 169 ++++++++++++++++
 tb/tb_lvds_echo_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_echo_pkg.sv
// Shared types and constants for the LVDS echo responder: FSM encodings,
// frame framing constants and a saturating counter helper.
package lvds_echo_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HI   = 2'd1,
        R_LO   = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SYNC = 2'd1,
        T_HI   = 2'd2,
        T_LO   = 2'd3
    } tx_state_e;

    // Both FSM state registers live in one struct so a checker can bind to it.
    typedef struct packed {
        rx_state_e rx;
        tx_state_e tx;
    } echo_state_t;

    localparam logic [3:0]  DEFAULT_SYNC_NIBBLE = 4'hA;
    localparam int unsigned FRAME_LEN           = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Single-clock byte FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate flag. Level is kept as its own register.
module echo_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [4:0]       o_level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [4:0]       r_level;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            r_level <= r_level + 5'(w_push) - 5'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/lvds_echo_responder.sv
// Far-end echo responder: reassembles SYNC/HI/LO nibble frames into bytes,
// buffers them and replays each byte on the return lanes with the same framing.
module lvds_echo_responder
    import lvds_echo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [3:0]  SYNC_NIBBLE = DEFAULT_SYNC_NIBBLE,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       rx_data,
    input  logic             rx_valid,
    input  logic             loop_en,
    output logic [3:0]       tx_data,
    output logic             tx_valid,
    output logic [CNT_W-1:0] rx_byte_cnt,
    output logic [7:0]       frame_err_cnt,
    output logic [7:0]       ovf_cnt,
    output logic [4:0]       fifo_level
);

    echo_state_t      r_state;
    logic [3:0]       r_rx_hi;
    logic [7:0]       r_tx_byte;
    logic [3:0]       r_tx_data;
    logic             r_tx_valid;
    logic [CNT_W-1:0] r_rx_byte_cnt;
    logic [7:0]       r_frame_err_cnt;
    logic [7:0]       r_ovf_cnt;

    rx_state_e        w_rx_next;
    tx_state_e        w_tx_next;
    logic             w_hi_load;
    logic             w_byte_done;
    logic             w_stray;
    logic             w_push;
    logic             w_ovf;
    logic             w_pop;
    logic [7:0]       w_byte;
    logic [7:0]       w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [4:0]       w_fifo_level;
    logic [3:0]       w_tx_data_next;
    logic             w_tx_valid_next;

    // RX framing: state only moves on a valid nibble, so gaps never break a frame.
    always_comb begin
        w_rx_next   = r_state.rx;
        w_hi_load   = 1'b0;
        w_byte_done = 1'b0;
        w_stray     = 1'b0;
        if (rx_valid) begin
            case (r_state.rx)
                R_IDLE: begin
                    if (rx_data == SYNC_NIBBLE) w_rx_next = R_HI;
                    else                        w_stray   = 1'b1;
                end
                R_HI: begin
                    w_hi_load = 1'b1;
                    w_rx_next = R_LO;
                end
                R_LO: begin
                    w_byte_done = 1'b1;
                    w_rx_next   = R_IDLE;
                end
                default: w_rx_next = R_IDLE;
            endcase
        end
    end

    assign w_byte = {r_rx_hi, rx_data};
    // Full is judged on registered occupancy, so a same-cycle pop never frees room.
    assign w_push = w_byte_done && loop_en && !w_fifo_full;
    assign w_ovf  = w_byte_done && loop_en &&  w_fifo_full;

    // TX sequencing: no backpressure, and T_LO chains straight into the next frame.
    always_comb begin
        w_tx_next       = r_state.tx;
        w_pop           = 1'b0;
        w_tx_data_next  = 4'h0;
        w_tx_valid_next = 1'b0;
        case (r_state.tx)
            T_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_tx_next = T_SYNC;
                end
            end
            T_SYNC: w_tx_next = T_HI;
            T_HI:   w_tx_next = T_LO;
            T_LO: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_tx_next = T_SYNC;
                end else begin
                    w_tx_next = T_IDLE;
                end
            end
            default: w_tx_next = T_IDLE;
        endcase
        case (w_tx_next)
            T_SYNC: begin
                w_tx_data_next  = SYNC_NIBBLE;
                w_tx_valid_next = 1'b1;
            end
            T_HI: begin
                w_tx_data_next  = r_tx_byte[7:4];
                w_tx_valid_next = 1'b1;
            end
            T_LO: begin
                w_tx_data_next  = r_tx_byte[3:0];
                w_tx_valid_next = 1'b1;
            end
            default: begin
                w_tx_data_next  = 4'h0;
                w_tx_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state.rx      <= R_IDLE;
            r_state.tx      <= T_IDLE;
            r_rx_hi         <= 4'h0;
            r_tx_byte       <= 8'h00;
            r_tx_data       <= 4'h0;
            r_tx_valid      <= 1'b0;
            r_rx_byte_cnt   <= '0;
            r_frame_err_cnt <= 8'h00;
            r_ovf_cnt       <= 8'h00;
        end else begin
            r_state.rx <= w_rx_next;
            r_state.tx <= w_tx_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            if (w_hi_load) r_rx_hi         <= rx_data;
            if (w_pop)     r_tx_byte       <= w_fifo_rdata;
            if (w_push)    r_rx_byte_cnt   <= r_rx_byte_cnt + CNT_W'(1);
            if (w_stray)   r_frame_err_cnt <= sat_inc8(r_frame_err_cnt);
            if (w_ovf)     r_ovf_cnt       <= sat_inc8(r_ovf_cnt);
        end
    end

    echo_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_wdata (w_byte),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign rx_byte_cnt   = r_rx_byte_cnt;
    assign frame_err_cnt = r_frame_err_cnt;
    assign ovf_cnt       = r_ovf_cnt;
    assign fifo_level    = w_fifo_level;

endmodule

// File: tb/tb_lvds_echo_responder.sv
// Scoreboard bench for lvds_echo_responder: a frame-level reference model
// schedules every expected return nibble by cycle; a monitor checks each cycle.
module tb_lvds_echo_responder;
    import lvds_echo_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [3:0] SYNC  = 4'hA;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  rx_data = 4'h0;
    logic        rx_valid = 1'b0;
    logic        loop_en = 1'b1;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic [15:0] rx_byte_cnt;
    logic [7:0]  frame_err_cnt;
    logic [7:0]  ovf_cnt;
    logic [4:0]  fifo_level;

    always #5 CLK = ~CLK;

    lvds_echo_responder #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_NIBBLE (SYNC),
        .CNT_W       (16)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .loop_en       (loop_en),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .rx_byte_cnt   (rx_byte_cnt),
        .frame_err_cnt (frame_err_cnt),
        .ovf_cnt       (ovf_cnt),
        .fifo_level    (fifo_level)
    );

    // Reference model state: exp_q entries are {cycle, nibble}.
    logic [35:0] exp_q[$];
    int          start_q[$];
    logic [3:0]  frame_q[$];
    int          cyc = 0;
    int          m_level = 0;
    int          m_rx_cnt = 0;
    int          m_err = 0;
    int          m_ovf = 0;
    int          last_start = -10;
    int          max_level = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        m_full;
    logic [7:0]  m_byte;
    int          st;
    logic [35:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        start_q.delete();
        frame_q.delete();
        m_level    = 0;
        m_rx_cnt   = 0;
        m_err      = 0;
        m_ovf      = 0;
        last_start = -10;
    endtask

    // Model: each completed byte is replayed starting one cycle after it lands,
    // or right after the previous 3-nibble frame, whichever is later.
    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            model_reset();
        end else begin
            cyc++;
            m_full = (m_level == DEPTH);
            while (start_q.size() > 0 && start_q[0] == cyc) begin
                void'(start_q.pop_front());
                m_level--;
            end
            if (rx_valid) begin
                if (frame_q.size() == 0) begin
                    if (rx_data == SYNC) frame_q.push_back(rx_data);
                    else if (m_err < 255) m_err++;
                end else begin
                    frame_q.push_back(rx_data);
                    if (frame_q.size() == FRAME_LEN) begin
                        m_byte = {frame_q[1], frame_q[2]};
                        frame_q.delete();
                        if (loop_en) begin
                            if (m_full) begin
                                if (m_ovf < 255) m_ovf++;
                            end else begin
                                m_rx_cnt = (m_rx_cnt + 1) % 65536;
                                st = (cyc + 1 > last_start + 3) ? cyc + 1 : last_start + 3;
                                last_start = st;
                                exp_q.push_back({st, SYNC});
                                exp_q.push_back({st + 1, m_byte[7:4]});
                                exp_q.push_back({st + 2, m_byte[3:0]});
                                start_q.push_back(st);
                                m_level++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare every output against the model away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (RST_N) begin
            if (exp_q.size() > 0 && exp_q[0][35:4] == cyc) begin
                e = exp_q.pop_front();
                chk("tx_valid", 32'(tx_valid), 32'd1);
                chk("tx_data", 32'(tx_data), 32'(e[3:0]));
            end else begin
                chk("tx_idle_valid", 32'(tx_valid), 32'd0);
                chk("tx_idle_data", 32'(tx_data), 32'd0);
            end
            chk("rx_byte_cnt", 32'(rx_byte_cnt), 32'(m_rx_cnt));
            chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            chk("fifo_level", 32'(fifo_level), 32'(m_level));
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    task automatic drive(input logic v, input logic [3:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1'b1, SYNC);
        drive(1'b1, b[7:4]);
        drive(1'b1, b[3:0]);
    endtask

    initial begin
        logic [7:0] rb;
        logic [3:0] nib;

        // Reset values
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rx_byte_cnt", 32'(rx_byte_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        RST_N = 1'b1;
        idle(2);

        // A,3,C contiguous: echo visible one edge after the low nibble edge
        send_byte(8'h3C);
        drive(1'b0, 4'h0);
        chk("lat_sync", 32'({tx_valid, tx_data}), 32'h1A);
        drive(1'b0, 4'h0);
        chk("lat_hi", 32'({tx_valid, tx_data}), 32'h13);
        drive(1'b0, 4'h0);
        chk("lat_lo", 32'({tx_valid, tx_data}), 32'h1C);
        chk("first_cnt", 32'(rx_byte_cnt), 32'd1);
        idle(4);

        // Gap of 4 idle cycles mid-frame
        drive(1'b1, SYNC);
        drive(1'b1, 4'h5);
        idle(4);
        drive(1'b1, 4'h6);
        idle(8);
        chk("gap_no_err", 32'(frame_err_cnt), 32'd0);

        // Stray nibble, then SYNC value used as high-nibble data
        drive(1'b1, 4'h7);
        drive(1'b1, 4'hA);
        drive(1'b1, 4'hA);
        drive(1'b1, 4'h1);
        idle(8);
        chk("stray_err", 32'(frame_err_cnt), 32'd1);

        // 12 back-to-back frames
        max_level = 0;
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
        end
        idle(10);
        chk("b2b_level_peak_le2", 32'(max_level <= 2), 32'd1);
        chk("b2b_ovf", 32'(ovf_cnt), 32'd0);
        chk("b2b_cnt", 32'(rx_byte_cnt), 32'd15);

        // loop_en=0 discards without counting; re-enable resumes echo
        loop_en = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        idle(6);
        chk("disabled_cnt", 32'(rx_byte_cnt), 32'd15);
        loop_en = 1'b1;
        send_byte(8'h5A);
        idle(8);
        chk("reenabled_cnt", 32'(rx_byte_cnt), 32'd16);

        // Randomized traffic with gaps, stray nibbles and loop_en toggling
        for (int i = 0; i < 600; i++) begin
            loop_en = ($urandom_range(0, 9) != 0);
            nib = ($urandom_range(0, 9) < 4) ? SYNC : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, nib);
        end
        loop_en = 1'b1;
        idle(12);

        // Saturate the stray-nibble counter
        for (int i = 0; i < 300; i++) begin
            nib = 4'($urandom_range(0, 14));
            if (nib >= 4'hA) nib = nib + 4'h1;
            drive(1'b1, nib);
        end
        idle(4);
        chk("err_saturated", 32'(frame_err_cnt), 32'd255);

        // Reset while the echo is in its high-nibble slot
        send_byte(8'hBC);
        drive(1'b0, 4'h0);
        drive(1'b0, 4'h0);
        chk("pre_rst_hi", 32'({tx_valid, tx_data}), 32'h1B);
        #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_cnt", 32'(rx_byte_cnt), 32'd0);
        chk("midrst_err", 32'(frame_err_cnt), 32'd0);
        chk("midrst_ovf", 32'(ovf_cnt), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(2);
        send_byte(8'hDE);
        idle(10);
        chk("post_rst_cnt", 32'(rx_byte_cnt), 32'd1);

        // Bounded drain of anything still scheduled
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
